// File: rtl/id_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : id_pkg
//  Description : Shared types and constants for the RV32I decode stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package id_pkg;

    localparam int c_XLEN = 32;

    localparam logic [6:0] c_OPC_OP     = 7'b0110011;
    localparam logic [6:0] c_OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'h0,
        ALU_SUB    = 4'h1,
        ALU_SLT    = 4'h2,
        ALU_SLTU   = 4'h3,
        ALU_XOR    = 4'h4,
        ALU_OR     = 4'h5,
        ALU_AND    = 4'h6,
        ALU_SLL    = 4'h7,
        ALU_SRL    = 4'h8,
        ALU_SRA    = 4'h9,
        ALU_PASS_B = 4'hF
    } alu_op_e;

    typedef enum logic [1:0] {
        OPA_RS1  = 2'd0,
        OPA_PC   = 2'd1,
        OPA_ZERO = 2'd2
    } opa_sel_e;

    typedef enum logic {
        OPB_RS2 = 1'b0,
        OPB_IMM = 1'b1
    } opb_sel_e;

    typedef struct packed {
        alu_op_e           alu_op;
        opa_sel_e          opa_sel;
        opb_sel_e          opb_sel;
        logic [c_XLEN-1:0] imm;
        logic [4:0]        rs1_addr;
        logic [4:0]        rs2_addr;
        logic [4:0]        rd_addr;
        logic              rd_wren;
        logic              mem_rd;
        logic              mem_wr;
        logic              br;
        logic              jmp;
        logic              illegal;
    } ctrl_t;

    // alt selects SUB over ADD and SRA over SRL (funct7[5])
    function automatic alu_op_e alu_from_funct(input logic [2:0] funct3, input logic alt);
        case (funct3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/inst_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : inst_decoder
//  Description : Combinational RV32I instruction word to control word decode.
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_decoder
    import id_pkg::*;
(
    input  logic [31:0] i_instr,
    output ctrl_t       o_ctrl
);

    logic [6:0]        w_opcode;
    logic [2:0]        w_funct3;
    logic [6:0]        w_funct7;
    logic [c_XLEN-1:0] w_imm_i;
    logic [c_XLEN-1:0] w_imm_s;
    logic [c_XLEN-1:0] w_imm_b;
    logic [c_XLEN-1:0] w_imm_u;
    logic [c_XLEN-1:0] w_imm_j;

    assign w_opcode = i_instr[6:0];
    assign w_funct3 = i_instr[14:12];
    assign w_funct7 = i_instr[31:25];

    assign w_imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
    assign w_imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
    assign w_imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
    assign w_imm_u = {i_instr[31:12], 12'b0};
    assign w_imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};

    always_comb begin
        o_ctrl          = '0;
        o_ctrl.alu_op   = ALU_ADD;
        o_ctrl.opa_sel  = OPA_RS1;
        o_ctrl.opb_sel  = OPB_RS2;
        o_ctrl.imm      = w_imm_i;
        o_ctrl.rs1_addr = i_instr[19:15];
        o_ctrl.rs2_addr = i_instr[24:20];
        o_ctrl.rd_addr  = i_instr[11:7];

        case (w_opcode)
            c_OPC_OP: begin
                o_ctrl.rd_wren = 1'b1;
                if (w_funct7 == 7'b0000000) begin
                    o_ctrl.alu_op = alu_from_funct(w_funct3, 1'b0);
                end else if (w_funct7 == 7'b0100000 &&
                             (w_funct3 == 3'b000 || w_funct3 == 3'b101)) begin
                    o_ctrl.alu_op = alu_from_funct(w_funct3, 1'b1);
                end else begin
                    o_ctrl.illegal = 1'b1;
                end
            end
            c_OPC_OP_IMM: begin
                o_ctrl.opb_sel = OPB_IMM;
                o_ctrl.rd_wren = 1'b1;
                // Only shift-right reads funct7[5]; ADDI never becomes SUB
                o_ctrl.alu_op  = alu_from_funct(w_funct3, (w_funct3 == 3'b101) && w_funct7[5]);
                if (w_funct3 == 3'b001 && w_funct7 != 7'b0000000)
                    o_ctrl.illegal = 1'b1;
                if (w_funct3 == 3'b101 && w_funct7 != 7'b0000000 && w_funct7 != 7'b0100000)
                    o_ctrl.illegal = 1'b1;
            end
            c_OPC_LUI: begin
                o_ctrl.alu_op  = ALU_PASS_B;
                o_ctrl.opa_sel = OPA_ZERO;
                o_ctrl.opb_sel = OPB_IMM;
                o_ctrl.imm     = w_imm_u;
                o_ctrl.rd_wren = 1'b1;
            end
            c_OPC_AUIPC: begin
                o_ctrl.opa_sel = OPA_PC;
                o_ctrl.opb_sel = OPB_IMM;
                o_ctrl.imm     = w_imm_u;
                o_ctrl.rd_wren = 1'b1;
            end
            c_OPC_JAL: begin
                o_ctrl.opa_sel = OPA_PC;
                o_ctrl.opb_sel = OPB_IMM;
                o_ctrl.imm     = w_imm_j;
                o_ctrl.jmp     = 1'b1;
                o_ctrl.rd_wren = 1'b1;
            end
            c_OPC_JALR: begin
                o_ctrl.opb_sel = OPB_IMM;
                o_ctrl.jmp     = 1'b1;
                o_ctrl.rd_wren = 1'b1;
                if (w_funct3 != 3'b000)
                    o_ctrl.illegal = 1'b1;
            end
            c_OPC_BRANCH: begin
                o_ctrl.opa_sel = OPA_PC;
                o_ctrl.opb_sel = OPB_IMM;
                o_ctrl.imm     = w_imm_b;
                o_ctrl.br      = 1'b1;
            end
            c_OPC_LOAD: begin
                o_ctrl.opb_sel = OPB_IMM;
                o_ctrl.mem_rd  = 1'b1;
                o_ctrl.rd_wren = 1'b1;
            end
            c_OPC_STORE: begin
                o_ctrl.opb_sel = OPB_IMM;
                o_ctrl.imm     = w_imm_s;
                o_ctrl.mem_wr  = 1'b1;
            end
            default: o_ctrl.illegal = 1'b1;
        endcase

        // An illegal word must not produce any architectural side effect
        if (o_ctrl.illegal) begin
            o_ctrl.alu_op  = ALU_ADD;
            o_ctrl.rd_wren = 1'b0;
            o_ctrl.mem_rd  = 1'b0;
            o_ctrl.mem_wr  = 1'b0;
            o_ctrl.br      = 1'b0;
            o_ctrl.jmp     = 1'b0;
        end

        if (o_ctrl.rd_addr == 5'd0)
            o_ctrl.rd_wren = 1'b0;
    end

endmodule
`default_nettype wire

// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_stage
//  Description : RV32I decode pipeline stage, one registered entry with
//                valid/ready handshake and branch-redirect flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module id_stage
    import id_pkg::*;
#(
    parameter int XLEN = c_XLEN,
    parameter int PC_W = 32
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_flush,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [31:0]     i_instr,
    input  logic [PC_W-1:0] i_pc,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [PC_W-1:0] o_pc,
    output logic [3:0]      o_alu_op,
    output logic [1:0]      o_opa_sel,
    output logic            o_opb_sel,
    output logic [XLEN-1:0] o_imm,
    output logic [4:0]      o_rs1_addr,
    output logic [4:0]      o_rs2_addr,
    output logic [4:0]      o_rd_addr,
    output logic            o_rd_wren,
    output logic            o_mem_rd,
    output logic            o_mem_wr,
    output logic            o_br,
    output logic            o_jmp,
    output logic            o_illegal
);

    ctrl_t           w_dec;
    ctrl_t           r_ctrl;
    logic            r_valid;
    logic [PC_W-1:0] r_pc;

    inst_decoder u_inst_decoder (
        .i_instr (i_instr),
        .o_ctrl  (w_dec)
    );

    assign o_ready = !r_valid || i_ready;

    // Flush wins over accept; data fields are only loaded on a real accept
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_ctrl  <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (o_ready) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_pc   <= i_pc;
                r_ctrl <= w_dec;
            end
        end
    end

    assign o_valid    = r_valid;
    assign o_pc       = r_pc;
    assign o_alu_op   = r_ctrl.alu_op;
    assign o_opa_sel  = r_ctrl.opa_sel;
    assign o_opb_sel  = r_ctrl.opb_sel;
    assign o_imm      = r_ctrl.imm;
    assign o_rs1_addr = r_ctrl.rs1_addr;
    assign o_rs2_addr = r_ctrl.rs2_addr;
    assign o_rd_addr  = r_ctrl.rd_addr;
    assign o_rd_wren  = r_ctrl.rd_wren;
    assign o_mem_rd   = r_ctrl.mem_rd;
    assign o_mem_wr   = r_ctrl.mem_wr;
    assign o_br       = r_ctrl.br;
    assign o_jmp      = r_ctrl.jmp;
    assign o_illegal  = r_ctrl.illegal;

endmodule
`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_stage
//  Description : Scoreboard bench for id_stage with hand-decoded vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_id_stage;

    logic        i_clk = 1'b0;
    logic        i_reset, i_flush, i_valid, i_ready;
    logic [31:0] i_instr, i_pc;
    logic        o_ready, o_valid, o_opb_sel, o_rd_wren, o_mem_rd, o_mem_wr, o_br, o_jmp, o_illegal;
    logic [31:0] o_pc, o_imm;
    logic [3:0]  o_alu_op;
    logic [1:0]  o_opa_sel;
    logic [4:0]  o_rs1_addr, o_rs2_addr, o_rd_addr;

    id_stage #(.XLEN(32), .PC_W(32)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_flush(i_flush), .i_valid(i_valid),
        .o_ready(o_ready), .i_instr(i_instr), .i_pc(i_pc), .o_valid(o_valid),
        .i_ready(i_ready), .o_pc(o_pc), .o_alu_op(o_alu_op), .o_opa_sel(o_opa_sel),
        .o_opb_sel(o_opb_sel), .o_imm(o_imm), .o_rs1_addr(o_rs1_addr),
        .o_rs2_addr(o_rs2_addr), .o_rd_addr(o_rd_addr), .o_rd_wren(o_rd_wren),
        .o_mem_rd(o_mem_rd), .o_mem_wr(o_mem_wr), .o_br(o_br), .o_jmp(o_jmp),
        .o_illegal(o_illegal)
    );

    always #5 i_clk = ~i_clk;

    // mask: [0] imm [1] opa [2] opb [3] rs1 [4] rd [5] rs2
    // flags: {rd_wren, mem_rd, mem_wr, br, jmp, illegal}
    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  op;
        logic [1:0]  opa;
        logic        opb;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [5:0]  flags;
        logic [5:0]  mask;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] pc, input logic [3:0] op, input logic [1:0] opa,
                                input logic opb, input logic [31:0] imm, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [4:0] rd,
                                input logic [5:0] flags, input logic [5:0] mask);
        exp_t e;
        e.pc = pc; e.op = op; e.opa = opa; e.opb = opb; e.imm = imm;
        e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.flags = flags; e.mask = mask;
        return e;
    endfunction

    // Monitor: a handshake at the mid-cycle sample retires the head entry
    always @(negedge i_clk) begin
        if (!i_reset && o_valid && i_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output actual_pc=%h expected=none", o_pc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("pc", o_pc, e.pc);
                chk("alu_op", {28'd0, o_alu_op}, {28'd0, e.op});
                chk("flags", {26'd0, o_rd_wren, o_mem_rd, o_mem_wr, o_br, o_jmp, o_illegal},
                    {26'd0, e.flags});
                if (e.mask[0]) chk("imm", o_imm, e.imm);
                if (e.mask[1]) chk("opa_sel", {30'd0, o_opa_sel}, {30'd0, e.opa});
                if (e.mask[2]) chk("opb_sel", {31'd0, o_opb_sel}, {31'd0, e.opb});
                if (e.mask[3]) chk("rs1", {27'd0, o_rs1_addr}, {27'd0, e.rs1});
                if (e.mask[4]) chk("rd", {27'd0, o_rd_addr}, {27'd0, e.rd});
                if (e.mask[5]) chk("rs2", {27'd0, o_rs2_addr}, {27'd0, e.rs2});
            end
        end else if (!i_reset && o_valid && i_flush && sb.size() != 0) begin
            void'(sb.pop_front());
        end
    end

    // Present one instruction and hold it until the stage takes it
    task automatic send(input logic [31:0] instr, input exp_t e);
        bit taken = 0;
        i_valid = 1'b1;
        i_instr = instr;
        i_pc    = e.pc;
        for (int n = 0; n < 50 && !taken; n++) begin
            @(negedge i_clk);
            if (o_ready) begin
                taken = 1;
                if (!i_flush) sb.push_back(e);
            end
            @(posedge i_clk); #1;
        end
        if (!taken) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=not_accepted expected=accepted pc=%h", e.pc);
        end
        i_valid = 1'b0;
    endtask

    int c0;

    initial begin
        i_reset = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
        i_instr = 32'h0; i_pc = 32'h0;
        #1;
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_ready", {31'd0, o_ready}, 32'd1);
        chk("rst_alu_op", {28'd0, o_alu_op}, 32'd0);
        chk("rst_pc", o_pc, 32'd0);
        chk("rst_imm", o_imm, 32'd0);
        chk("rst_rd_wren", {31'd0, o_rd_wren}, 32'd0);
        repeat (2) @(posedge i_clk);
        #1 i_reset = 1'b0;

        // Back-to-back stream at full throughput
        i_ready = 1'b1;
        c0 = cyc;
        send(32'h002081B3, mk(32'h100, 4'h0, 2'd0, 1'b0, 32'h0, 5'd1, 5'd2, 5'd3, 6'b100000, 6'b111110));
        send(32'h40435293, mk(32'h104, 4'h9, 2'd0, 1'b1, 32'h404, 5'd6, 5'd0, 5'd5, 6'b100000, 6'b011111));
        send(32'hABCDE3B7, mk(32'h108, 4'hF, 2'd0, 1'b1, 32'hABCDE000, 5'd0, 5'd0, 5'd7, 6'b100000, 6'b010101));
        send(32'hFE208EE3, mk(32'h10C, 4'h0, 2'd1, 1'b1, 32'hFFFFFFFC, 5'd1, 5'd2, 5'd0, 6'b000100, 6'b101111));
        chk("throughput_cycles", cyc - c0, 32'd4);
        repeat (2) @(posedge i_clk);
        #1;

        // Back-pressure: addi held while sw waits
        i_ready = 1'b0;
        send(32'hFFF00513, mk(32'h200, 4'h0, 2'd0, 1'b1, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd10, 6'b100000, 6'b011111));
        i_valid = 1'b1; i_instr = 32'h0020A423; i_pc = 32'h204;
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            chk("stall_ready", {31'd0, o_ready}, 32'd0);
            chk("stall_valid", {31'd0, o_valid}, 32'd1);
            chk("stall_pc", o_pc, 32'h200);
            chk("stall_imm", o_imm, 32'hFFFFFFFF);
            @(posedge i_clk); #1;
        end
        i_ready = 1'b1;
        send(32'h0020A423, mk(32'h204, 4'h0, 2'd0, 1'b1, 32'h8, 5'd1, 5'd2, 5'd0, 6'b001000, 6'b101111));
        chk("release_valid", {31'd0, o_valid}, 32'd1);
        chk("release_pc", o_pc, 32'h204);
        @(posedge i_clk); #1;

        // Flush a stalled lw while a jal is being presented
        i_ready = 1'b0;
        send(32'hFF812203, mk(32'h208, 4'h0, 2'd0, 1'b1, 32'hFFFFFFF8, 5'd2, 5'd0, 5'd4, 6'b110000, 6'b011111));
        i_valid = 1'b1; i_instr = 32'h008000EF; i_pc = 32'h20C; i_flush = 1'b1;
        @(posedge i_clk); #1;
        i_flush = 1'b0; i_valid = 1'b0;
        chk("flush_valid", {31'd0, o_valid}, 32'd0);
        i_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            chk("post_flush_valid", {31'd0, o_valid}, 32'd0);
        end
        @(posedge i_clk); #1;

        // Illegal words, rd = x0 suppression, jal
        send(32'h0000007F, mk(32'h300, 4'h0, 2'd0, 1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 6'b000001, 6'b000000));
        send(32'h022081B3, mk(32'h304, 4'h0, 2'd0, 1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 6'b000001, 6'b000000));
        send(32'h40208033, mk(32'h308, 4'h1, 2'd0, 1'b0, 32'h0, 5'd1, 5'd2, 5'd0, 6'b000000, 6'b111110));
        send(32'h008000EF, mk(32'h30C, 4'h0, 2'd1, 1'b1, 32'h8, 5'd0, 5'd0, 5'd1, 6'b100010, 6'b010111));
        for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge i_clk);
        #1;
        chk("scoreboard_drained", sb.size(), 32'd0);

        // Asynchronous reset in the middle of a stall
        i_ready = 1'b0;
        send(32'hFFF00513, mk(32'h400, 4'h0, 2'd0, 1'b1, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd10, 6'b100000, 6'b011111));
        chk("pre_reset_valid", {31'd0, o_valid}, 32'd1);
        #2 i_reset = 1'b1;
        #1;
        chk("async_reset_valid", {31'd0, o_valid}, 32'd0);
        chk("async_reset_alu_op", {28'd0, o_alu_op}, 32'd0);
        sb.delete();
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        i_ready = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        chk("after_reset_valid", {31'd0, o_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode pipeline stage for the RV32I core.
- Turns a fetched 32-bit instruction into the control word for the execute stage: ALU op code, operand selects, register addresses, immediate and writeback enable.
- Sits between fetch and execute, and is the producing end of the ALU's i_alu_op / operand interface.
- One registered entry with a valid/ready handshake on both sides, plus a flush input.

Parameters:
- XLEN, 32, data and immediate width.
- PC_W, 32, program-counter width.

Ports:
- i_clk  in  1  clock, rising edge
- i_reset  in  1  asynchronous reset, active-high
- i_flush  in  1  discard held and incoming instruction (branch redirect)
- i_valid  in  1  upstream instruction valid
- o_ready  out  1  stage can accept an instruction this cycle
- i_instr  in  32  instruction word
- i_pc  in  PC_W  instruction address
- o_valid  out  1  decoded entry valid
- i_ready  in  1  downstream accepts the entry
- o_pc  out  PC_W  registered pc
- o_alu_op  out  4  ALU op code
- o_opa_sel  out  2  operand A source: 0 = rs1, 1 = pc, 2 = zero
- o_opb_sel  out  1  operand B source: 0 = rs2, 1 = imm
- o_imm  out  XLEN  sign-extended immediate
- o_rs1_addr / o_rs2_addr / o_rd_addr  out  5 each  register indices
- o_rd_wren  out  1  register writeback enable
- o_mem_rd / o_mem_wr  out  1 each  load / store
- o_br / o_jmp  out  1 each  conditional branch / jal or jalr
- o_illegal  out  1  undecodable instruction

Behaviour:
- Clock and reset: single clock i_clk; i_reset is asynchronous active-high. Reset drives every registered output to 0, including o_valid = 0 and o_alu_op = ADD (4'h0).
- Handshake:
  - o_ready = !o_valid | i_ready (combinational).
  - An instruction is accepted when i_valid & o_ready. Its decoded fields appear on the outputs with o_valid = 1 on the next edge (latency 1).
  - With o_valid = 1 and i_ready = 0, all outputs hold stable.
  - Simultaneous accept and downstream consume gives full throughput, one instruction per cycle.
- Flush:
  - i_flush = 1 clears o_valid at the next edge and drops any instruction presented in the same cycle, even if accepted.
  - Flush has priority over accept. Data fields may keep stale values while o_valid = 0.
- ALU op codes: ADD 0, SUB 1, SLT 2, SLTU 3, XOR 4, OR 5, AND 6, SLL 7, SRL 8, SRA 9, PASS_B F. Codes A to E are never emitted.
- Decode by opcode [6:0]:
  - 0110011 R-type: op from funct3 and funct7[5]; A = rs1, B = rs2; rd_wren = 1.
  - 0010011 I-ALU: same mapping with B = imm. funct7[5] is used only for the shift right (SRA vs SRL); no SUBI.
  - 0110111 LUI: PASS_B, B = imm U.
  - 0010111 AUIPC: ADD, A = pc, B = imm U.
  - 1101111 JAL: ADD, A = pc, B = imm J; o_jmp = 1, rd_wren = 1.
  - 1100111 JALR (funct3 = 000): ADD, A = rs1, B = imm I; o_jmp = 1, rd_wren = 1.
  - 1100011 branch: ADD, A = pc, B = imm B; o_br = 1, rd_wren = 0.
  - 0000011 load: ADD, rs1 + imm I; o_mem_rd = 1, rd_wren = 1.
  - 0100011 store: ADD, rs1 + imm S; o_mem_wr = 1, rd_wren = 0.
- Immediate formats:
  - I = {20{b31}, [31:20]}
  - S = {20{b31}, [31:25], [11:7]}
  - B = {19{b31}, b31, b7, [30:25], [11:8], 0}
  - U = {[31:12], 12'b0}
  - J = {11{b31}, b31, [19:12], b20, [30:21], 0}
- Illegal instruction:
  - Triggered by an unknown opcode, by R-type funct7 not in {0000000, 0100000}, by 0100000 with funct3 not in {000, 101}, or by an I-shift with a bad funct7.
  - Output: o_illegal = 1, op = ADD, and rd_wren, mem_rd, mem_wr, br and jmp all 0. o_valid is still asserted.
- rd = x0: o_rd_wren is forced to 0 when rd_addr = 0.

Decomposition:
- Package id_pkg holds:
  - the alu_op_e enum (4-bit, values above);
  - opcode localparams;
  - opa_sel_e and opb_sel_e;
  - a packed struct ctrl_t grouping all decoded fields.
- Sub-module inst_decoder: purely combinational, i_instr -> ctrl_t.
- id_stage wraps inst_decoder with the handshake and flush register.

Test Plan:
- `add x3,x1,x2` (0x002081B3) with i_valid and i_ready high -> next cycle: o_valid = 1, alu_op = 0, rs1 = 1, rs2 = 2, rd = 3, opb_sel = 0, rd_wren = 1.
- `srai x5,x6,4` (0x40435293) -> alu_op = 9, opb_sel = 1, imm = 0x404 (bits [31:20]), rd_wren = 1.
- `lui x7,0xABCDE` (0xABCDE3B7) -> alu_op = F, imm = 0xABCDE000. Then `beq` with offset -4 -> o_br = 1, imm = 0xFFFFFFFC, opa_sel = 1.
- Back-pressure: hold i_ready = 0 for 3 cycles with a new i_valid pending -> o_ready = 0, outputs stable. Release i_ready -> next instruction appears the following cycle.
- Flush while holding a stalled entry and presenting a new one -> o_valid = 0 next cycle, and the new instruction never appears.
- Opcode 0x7F or an R-type with funct7 = 0x01 -> o_illegal = 1, rd_wren = 0. Assert i_reset mid-stall -> o_valid = 0 immediately, without waiting for a clock edge.
